// File: rtl/load_data_aligner.sv
// RV64 load aligner: issues one doubleword read per load, then lane-selects and extends the result.
// Optional: LOAD_ALIGNER_MISALIGN_TRAP_EN turns misaligned H/W/D loads into errors instead of rounding.

// state | meaning
// IDLE  | ready for a request; memory responses are dropped
// ISSUE | memory read presented, waiting for mem_req_ready
// WAIT  | read accepted, waiting for mem_resp_valid
// DONE  | result presented, held until load_ready
module load_data_aligner #(
    parameter int ADDRESS_WIDTH = 64,
    parameter int XLEN          = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [2:0]               req_funct3,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_req_address,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_data,
    output logic                     load_valid,
    input  logic                     load_ready,
    output logic [XLEN-1:0]          load_data,
    output logic                     load_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      funct3_q;
    logic [2:0]      offset_q;
    logic [2:0]      req_offset;
    logic            req_error;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] extended;

    // Request decode: error flag and the byte offset actually used for lane select.
    always_comb begin
        req_error  = (req_funct3 == 3'b111);
        req_offset = req_address[2:0];
`ifdef LOAD_ALIGNER_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'd1:    req_error = req_error | req_address[0];
            2'd2:    req_error = req_error | (|req_address[1:0]);
            2'd3:    req_error = req_error | (|req_address[2:0]);
            default: req_error = req_error;
        endcase
`else
        case (req_funct3[1:0])
            2'd1:    req_offset = {req_address[2:1], 1'b0};
            2'd2:    req_offset = {req_address[2], 2'b00};
            2'd3:    req_offset = 3'b000;
            default: req_offset = req_address[2:0];
        endcase
`endif
    end

    // Lane select and extension of the returned doubleword.
    always_comb begin
        shifted  = mem_resp_data >> {offset_q, 3'b000};
        extended = '0;
        case (funct3_q)
            3'b000:  extended = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  extended = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  extended = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b011:  extended = shifted;
            3'b100:  extended = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  extended = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  extended = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: extended = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        load_valid    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_error ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                load_valid = 1'b1;
                if (load_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req_address <= '0;
            funct3_q        <= 3'b000;
            offset_q        <= 3'b000;
            load_data       <= '0;
            load_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_req_address <= {req_address[ADDRESS_WIDTH-1:3], 3'b000};
                        funct3_q        <= req_funct3;
                        offset_q        <= req_offset;
                        load_error      <= req_error;
                        if (req_error) begin
                            load_data <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        load_data <= extended;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_data_aligner.sv
// Scoreboard bench for load_data_aligner: directed cases plus randomized loads vs. an arithmetic model.
// Build with LOAD_ALIGNER_MISALIGN_TRAP_EN defined to check the trapping variant.
module tb_load_data_aligner;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_address;
    logic [2:0]  req_funct3;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_address;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        load_valid;
    logic        load_ready;
    logic [63:0] load_data;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    logic [64:0] exp_q[$];
    logic [63:0] addr_q[$];

    load_data_aligner #(.ADDRESS_WIDTH(64), .XLEN(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .req_funct3      (req_funct3),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_address (mem_req_address),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_data       (load_data),
        .load_error      (load_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: returns {error, value} from the load rules using plain arithmetic.
    function automatic logic [64:0] model(input logic [63:0] addr, input logic [2:0] f3,
                                          input logic [63:0] data);
        int          nb;
        int          off;
        bit          err;
        logic [63:0] mask;
        logic [63:0] val;
        nb  = 1 << f3[1:0];
        off = int'(addr[2:0]);
        err = (f3 == 3'b111);
`ifdef LOAD_ALIGNER_MISALIGN_TRAP_EN
        if ((off % nb) != 0) err = 1'b1;
`else
        off = off - (off % nb);
`endif
        if (err) return {1'b1, 64'd0};
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        val  = (data >> (8 * off)) & mask;
        if (!f3[2] && nb < 8 && val[8 * nb - 1]) val = val | ~mask;
        return {1'b0, val};
    endfunction

    // Monitor: scoreboard pops on handshakes plus stability / ready checks.
    logic        prev_lv, prev_lr, prev_le, prev_mv, prev_mr;
    logic [63:0] prev_ld, prev_ma;
    logic [64:0] mon_e;
    logic [63:0] mon_a;

    always @(negedge clock) begin
        if (reset) begin
            prev_lv = 1'b0;
            prev_mv = 1'b0;
            prev_lr = 1'b0;
            prev_mr = 1'b0;
        end else begin
            if (load_valid && load_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load actual=%h required=none", load_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("load_data", load_data, mon_e[63:0]);
                    check("load_error", {63'd0, load_error}, {63'd0, mon_e[64]});
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req actual=%h required=none", mem_req_address);
                end else begin
                    mon_a = addr_q.pop_front();
                    check("mem_req_address", mem_req_address, mon_a);
                end
            end
            if (load_valid && prev_lv && !prev_lr) begin
                check("load_data_stable", load_data, prev_ld);
                check("load_error_stable", {63'd0, load_error}, {63'd0, prev_le});
            end
            if (mem_req_valid && prev_mv && !prev_mr)
                check("mem_addr_stable", mem_req_address, prev_ma);
            if (load_valid || mem_req_valid)
                check("req_ready_busy", {63'd0, req_ready}, 64'd0);
            prev_lv = load_valid;
            prev_lr = load_ready;
            prev_ld = load_data;
            prev_le = load_error;
            prev_mv = mem_req_valid;
            prev_mr = mem_req_ready;
            prev_ma = mem_req_address;
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drives one complete load; the expectation goes to the scoreboard before the request.
    task automatic do_load(input logic [63:0] addr, input logic [2:0] f3, input logic [63:0] data,
                           input int mstall, input int rdelay, input int lstall);
        int          n;
        logic [64:0] e;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 required=1");
            return;
        end
        e = model(addr, f3, data);
        exp_q.push_back(e);
        if (!e[64]) addr_q.push_back({addr[63:3], 3'b000});
        req_valid      = 1'b1;
        req_address    = addr;
        req_funct3     = f3;
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data  = rnd64();
        @(posedge clock); #1;
        req_valid      = 1'b0;
        req_address    = rnd64();
        req_funct3     = 3'($urandom_range(0, 7));
        mem_resp_valid = 1'b0;
        if (e[64]) begin
            check("err_latency_valid", {63'd0, load_valid}, 64'd1);
            check("err_no_mem_req", {63'd0, mem_req_valid}, 64'd0);
        end else begin
            for (int i = 0; i < mstall; i++) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'($urandom_range(0, 1));
                mem_resp_data  = rnd64();
                check("issue_mem_valid", {63'd0, mem_req_valid}, 64'd1);
                @(posedge clock); #1;
            end
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = rnd64();
            check("issue_mem_valid", {63'd0, mem_req_valid}, 64'd1);
            @(posedge clock); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            for (int i = 0; i < rdelay; i++) begin
                check("wait_no_load_valid", {63'd0, load_valid}, 64'd0);
                check("wait_no_mem_valid", {63'd0, mem_req_valid}, 64'd0);
                @(posedge clock); #1;
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = data;
            @(posedge clock); #1;
            mem_resp_valid = 1'b0;
            mem_resp_data  = rnd64();
            check("done_load_valid", {63'd0, load_valid}, 64'd1);
        end
        for (int i = 0; i < lstall; i++) begin
            load_ready = 1'b0;
            check("hold_load_valid", {63'd0, load_valid}, 64'd1);
            @(posedge clock); #1;
        end
        load_ready = 1'b1;
        @(posedge clock); #1;
        load_ready = 1'b0;
        check("back_idle_ready", {63'd0, req_ready}, 64'd1);
        check("back_idle_no_valid", {63'd0, load_valid}, 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_address    = '0;
        req_funct3     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        load_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_load_valid", {63'd0, load_valid}, 64'd0);
        check("rst_load_data", load_data, 64'd0);
        check("rst_load_error", {63'd0, load_error}, 64'd0);
        check("rst_mem_req_address", mem_req_address, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_load(64'h1003, 3'b000, 64'h0000_0000_8000_0000, 0, 0, 0);
        do_load(64'h2006, 3'b101, 64'hBEEF_0000_0000_0000, 0, 0, 0);
        do_load(64'h2004, 3'b010, 64'h8765_4321_0000_0000, 0, 0, 0);
        do_load(64'h2004, 3'b110, 64'h8765_4321_0000_0000, 0, 0, 0);
        do_load(64'h3001, 3'b011, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        do_load(64'h5008, 3'b111, 64'h1111_2222_3333_4444, 0, 0, 2);
        do_load(64'h6005, 3'b001, 64'hFEDC_BA98_7654_3210, 4, 1, 3);

        // Reset while waiting for the memory response; the late response must be dropped.
        addr_q.push_back(64'h4000);
        req_valid   = 1'b1;
        req_address = 64'h4000;
        req_funct3  = 3'b011;
        @(posedge clock); #1;
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rstwait_req_ready", {63'd0, req_ready}, 64'd1);
        check("rstwait_load_valid", {63'd0, load_valid}, 64'd0);
        @(posedge clock); #1;
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clock); #1;
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_valid", {63'd0, load_valid}, 64'd0);
            check("post_rst_idle", {63'd0, req_ready}, 64'd1);
            @(posedge clock); #1;
        end
        do_load(64'h7002, 3'b100, 64'h0000_0000_00A5_0000, 0, 0, 0);

        for (int t = 0; t < 80; t++) begin
            do_load(rnd64(), 3'($urandom_range(0, 7)), rnd64(),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("mem_queue_drained", 64'(addr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
